// File: rtl/spi_cipher_pkg.sv
// Shared definitions for the SPI cipher controller: opcodes, FSM encoding,
// status byte layout and small decode helpers.
package spi_cipher_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RX_CMD  = 3'd1,
      ST_RX_DATA = 3'd2,
      ST_ARM     = 3'd3,
      ST_RUN     = 3'd4
   } state_t;

   localparam logic [7:0] OP_STATUS  = 8'h00;
   localparam logic [7:0] OP_ECB_ENC = 8'h01;
   localparam logic [7:0] OP_ECB_DEC = 8'h02;
   localparam logic [7:0] OP_CBC_ENC = 8'h03;
   localparam logic [7:0] OP_CBC_DEC = 8'h04;
   localparam logic [7:0] OP_LOAD_IV = 8'h05;

   localparam int STAT_BUSY = 7;
   localparam int STAT_RV   = 6;
   localparam int STAT_ERR  = 5;

   // Opcodes that launch the external cipher core.
   function automatic logic is_cipher_op(input logic [7:0] op);
      return (op == OP_ECB_ENC) || (op == OP_ECB_DEC) ||
             (op == OP_CBC_ENC) || (op == OP_CBC_DEC);
   endfunction

   // Status byte shifted out during the command phase; low bits read as zero.
   function automatic logic [7:0] status_byte(input logic busy, input logic rv,
                                              input logic err);
      logic [7:0] s;
      s            = 8'h00;
      s[STAT_BUSY] = busy;
      s[STAT_RV]   = rv;
      s[STAT_ERR]  = err;
      return s;
   endfunction

endpackage

// File: rtl/spi_cipher_ctrl_if.sv
// SPI pins, status outputs and cipher-core handshake bundled together.
// slave = controller view, master = host/core-side view.
interface spi_cipher_ctrl_if #(parameter int BLOCK_W = 64);
   logic               cs_n;
   logic               mosi;
   logic               miso;
   logic               busy;
   logic               err;
   logic               core_start;
   logic               core_encrypt;
   logic [BLOCK_W-1:0] core_text_in;
   logic               core_done;
   logic [BLOCK_W-1:0] core_text_out;

   modport slave (
      input  cs_n, mosi, core_done, core_text_out,
      output miso, busy, err, core_start, core_encrypt, core_text_in
   );

   modport master (
      output cs_n, mosi, core_done, core_text_out,
      input  miso, busy, err, core_start, core_encrypt, core_text_in
   );
endinterface

// File: rtl/spi_cipher_ctrl_shift.sv
// Serial-in, parallel-out shift register (MSB first) for the received block.
module shift_register #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             shift_en,
   input  logic             sin,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] sr_q, sr_d;

   // Shift one bit in at the LSB end when enabled, otherwise hold.
   always_comb begin
      sr_d = sr_q;
      if (shift_en) begin
         sr_d = {sr_q[WIDTH-2:0], sin};
      end
   end

   // Register update with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign q = sr_q;

endmodule

// File: rtl/spi_cipher_ctrl.sv
// SPI front end for an external block-cipher core: receives command + block
// frames, runs ECB/CBC around the core, and streams status/result on miso.
module spi_cipher_ctrl
   import spi_cipher_pkg::*;
#(
   parameter int                 BLOCK_W  = 64,
   parameter logic [BLOCK_W-1:0] IV_RESET = '0
) (
   input logic              clk,
   input logic              rst,
   spi_cipher_ctrl_if.slave bus
);

   localparam int CNT_W = $clog2(BLOCK_W + 1);

   state_t             state_q, state_d;
   logic [3:0]         cmd_cnt_q, cmd_cnt_d;
   logic [CNT_W-1:0]   data_cnt_q, data_cnt_d;
   logic [7:0]         cmd_q, cmd_d;
   logic [7:0]         stat_q, stat_d;
   logic               ign_q, ign_d;
   logic               miso_q, miso_d;
   logic               err_q, err_d;
   logic               rv_q, rv_d;
   logic               start_q, start_d;
   logic               enc_q, enc_d;
   logic [BLOCK_W-1:0] tin_q, tin_d;
   logic [BLOCK_W-1:0] result_q, result_d;
   logic [BLOCK_W-1:0] chain_q, chain_d;

   logic               busy;
   logic               data_shift_en;
   logic               frame_full;
   logic               data_read_out;
   logic [7:0]         status_now;
   logic [7:0]         stat_sh;
   logic [BLOCK_W-1:0] result_sh;
   logic [BLOCK_W-1:0] data;

   assign busy       = (state_q == ST_ARM) || (state_q == ST_RUN);
   assign status_now = status_byte(busy, rv_q, err_q);
   assign stat_sh    = stat_q << cmd_cnt_q;
   assign result_sh  = result_q << data_cnt_q;
   assign frame_full = (data_cnt_q == CNT_W'(BLOCK_W));
   assign data_read_out = !bus.cs_n && (cmd_cnt_q == 4'd8) &&
                          (data_cnt_q == CNT_W'(BLOCK_W - 1));

   shift_register #(.WIDTH(BLOCK_W)) u_data_sr (
      .clk      (clk),
      .rst      (rst),
      .shift_en (data_shift_en),
      .sin      (bus.mosi),
      .q        (data)
   );

   // Frame bit counting, command capture and miso stream; runs for every
   // frame, including ones that arrive while the core is busy.
   always_comb begin
      cmd_cnt_d     = cmd_cnt_q;
      data_cnt_d    = data_cnt_q;
      cmd_d         = cmd_q;
      stat_d        = stat_q;
      ign_d         = ign_q;
      miso_d        = 1'b0;
      data_shift_en = 1'b0;
      if (bus.cs_n) begin
         cmd_cnt_d  = '0;
         data_cnt_d = '0;
         ign_d      = 1'b0;
      end else begin
         if (busy) begin
            ign_d = 1'b1;
         end
         if (cmd_cnt_q != 4'd8) begin
            cmd_cnt_d = cmd_cnt_q + 4'd1;
            if (!ign_q && (state_q == ST_IDLE || state_q == ST_RX_CMD)) begin
               cmd_d = {cmd_q[6:0], bus.mosi};
            end
            // Status is frozen at the first bit so the byte reads consistently.
            if (cmd_cnt_q == 4'd0) begin
               stat_d = status_now;
               miso_d = status_now[7];
            end else begin
               miso_d = stat_sh[7];
            end
         end else if (!frame_full) begin
            data_cnt_d    = data_cnt_q + CNT_W'(1);
            data_shift_en = (state_q == ST_RX_DATA);
            miso_d        = result_sh[BLOCK_W-1];
         end
      end
   end

   // Control FSM: frame decode on cs_n rise, core launch and completion.
   always_comb begin
      state_d  = state_q;
      err_d    = err_q;
      rv_d     = rv_q;
      enc_d    = enc_q;
      tin_d    = tin_q;
      result_d = result_q;
      chain_d  = chain_q;
      if (data_read_out) begin
         rv_d = 1'b0;
      end
      case (state_q)
         ST_IDLE: begin
            if (!bus.cs_n && !ign_q) begin
               state_d = ST_RX_CMD;
            end
         end
         ST_RX_CMD: begin
            if (bus.cs_n) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else if (cmd_cnt_q == 4'd7) begin
               state_d = ST_RX_DATA;
            end
         end
         ST_RX_DATA: begin
            if (bus.cs_n) begin
               state_d = ST_IDLE;
               if (!frame_full) begin
                  err_d = 1'b1;
               end else if (is_cipher_op(cmd_q)) begin
                  state_d = ST_ARM;
                  enc_d   = (cmd_q == OP_ECB_ENC) || (cmd_q == OP_CBC_ENC);
                  tin_d   = (cmd_q == OP_CBC_ENC) ? (data ^ chain_q) : data;
               end else if (cmd_q == OP_LOAD_IV) begin
                  chain_d = data;
               end else if (cmd_q == OP_STATUS) begin
                  err_d = 1'b0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_ARM: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (bus.core_done) begin
               state_d  = ST_IDLE;
               rv_d     = 1'b1;
               result_d = (cmd_q == OP_CBC_DEC) ? (bus.core_text_out ^ chain_q)
                                                : bus.core_text_out;
               if (cmd_q == OP_CBC_ENC) begin
                  chain_d = bus.core_text_out;
               end else if (cmd_q == OP_CBC_DEC) begin
                  chain_d = data;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // A frame that opens while the core is in flight is an error.
      if (!bus.cs_n && busy) begin
         err_d = 1'b1;
      end
      start_d = (state_d == ST_ARM);
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Frame, datapath and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_cnt_q  <= '0;
         data_cnt_q <= '0;
         cmd_q      <= '0;
         stat_q     <= '0;
         ign_q      <= 1'b0;
         miso_q     <= 1'b0;
         err_q      <= 1'b0;
         rv_q       <= 1'b0;
         start_q    <= 1'b0;
         enc_q      <= 1'b0;
         tin_q      <= '0;
         result_q   <= '0;
         chain_q    <= IV_RESET;
      end else begin
         cmd_cnt_q  <= cmd_cnt_d;
         data_cnt_q <= data_cnt_d;
         cmd_q      <= cmd_d;
         stat_q     <= stat_d;
         ign_q      <= ign_d;
         miso_q     <= miso_d;
         err_q      <= err_d;
         rv_q       <= rv_d;
         start_q    <= start_d;
         enc_q      <= enc_d;
         tin_q      <= tin_d;
         result_q   <= result_d;
         chain_q    <= chain_d;
      end
   end

   assign bus.miso         = miso_q;
   assign bus.busy         = busy;
   assign bus.err          = err_q;
   assign bus.core_start   = start_q;
   assign bus.core_encrypt = enc_q;
   assign bus.core_text_in = tin_q;

endmodule

// File: tb/tb_spi_cipher_ctrl.sv
// Testbench for spi_cipher_ctrl: core stub, frame driver, miso scoreboard.
module tb_spi_cipher_ctrl;
   import spi_cipher_pkg::*;

   localparam int          BW   = 64;
   localparam logic [63:0] MASK = 64'hFFFF0000FFFF0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spi_cipher_ctrl_if #(.BLOCK_W(BW)) bus ();

   spi_cipher_ctrl #(.BLOCK_W(BW), .IV_RESET(64'h0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Cipher core stub: out = in ^ MASK, done 16 cycles after start.
   logic        done_r   = 1'b0;
   logic [63:0] stub_out = '0;
   logic [63:0] last_tin = '0;
   int          stub_cnt = 0;
   int          n_start  = 0;
   int          n_done   = 0;
   assign bus.core_done     = done_r;
   assign bus.core_text_out = stub_out;

   always @(posedge clk) begin
      done_r <= 1'b0;
      if (bus.core_start) begin
         stub_cnt <= 16;
         stub_out <= bus.core_text_in ^ MASK;
         last_tin <= bus.core_text_in;
         n_start  <= n_start + 1;
      end else if (stub_cnt != 0) begin
         stub_cnt <= stub_cnt - 1;
         if (stub_cnt == 1) begin
            done_r <= 1'b1;
            n_done <= n_done + 1;
         end
      end
   end

   // Scoreboard of expected miso content per frame.
   typedef struct {
      logic [7:0]  stat;
      logic        chk_data;
      logic [63:0] data;
   } exp_t;
   exp_t sb_q[$];
   logic rx[$];

   task automatic check_frame();
      exp_t        e;
      logic [7:0]  s;
      logic [63:0] d;
      if (sb_q.size() == 0) begin
         chk("sb_unexpected_frame", 64'(rx.size()), 64'd0);
         return;
      end
      e = sb_q.pop_front();
      if (rx.size() >= 8) begin
         s = '0;
         for (int i = 0; i < 8; i++) s = {s[6:0], rx[i]};
         chk("status_byte", 64'(s), 64'(e.stat));
      end
      if (e.chk_data && rx.size() >= 72) begin
         d = '0;
         for (int i = 0; i < 64; i++) d = {d[62:0], rx[8+i]};
         chk("result_read", d, e.data);
      end
   endtask

   // Monitor: collect miso bits per frame, compare when cs_n rises.
   always begin
      @(posedge clk);
      #1;
      if (!bus.cs_n) begin
         rx.push_back(bus.miso);
      end else if (rx.size() != 0) begin
         check_frame();
         rx.delete();
      end
   end

   // Reference model state.
   logic        m_err = 0, m_rv = 0, m_busy = 0;
   logic [63:0] m_result = '0, m_chain = '0;
   logic [63:0] p_result = '0, p_chain = '0, exp_tin = '0;
   logic        exp_enc = 0;
   int          s_start = 0;

   task automatic model_reset();
      m_err = 0; m_rv = 0; m_busy = 0; m_result = '0; m_chain = '0;
   endtask

   // Drive one frame; optional literal expectations override the model.
   task automatic send_frame(input logic [7:0] op, input logic [63:0] data, input int nbits,
                             input logic use_lit, input logic [7:0] lit_stat,
                             input logic [63:0] lit_data);
      exp_t        e;
      logic [71:0] fr;
      logic [63:0] core_out;
      e.stat     = use_lit ? lit_stat : {m_busy, m_rv, m_err, 5'b0};
      e.chk_data = !m_busy;
      e.data     = use_lit ? lit_data : m_result;
      sb_q.push_back(e);
      fr = {op, data};
      if (!m_busy) s_start = n_start;
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         bus.cs_n = 1'b0;
         bus.mosi = (i < 72) ? fr[71-i] : 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      bus.cs_n = 1'b1;
      bus.mosi = 1'b0;
      @(negedge clk);
      if (nbits >= 72) m_rv = 0;
      if (m_busy) m_err = 1;
      else if (nbits < 72) m_err = 1;
      else begin
         case (op)
            8'h00: m_err = 0;
            8'h05: m_chain = data;
            8'h01, 8'h02: begin
               exp_tin = data; exp_enc = (op == 8'h01);
               p_result = data ^ MASK; p_chain = m_chain; m_busy = 1;
            end
            8'h03: begin
               exp_tin = data ^ m_chain; exp_enc = 1;
               p_result = exp_tin ^ MASK; p_chain = p_result; m_busy = 1;
            end
            8'h04: begin
               exp_tin = data; exp_enc = 0;
               core_out = data ^ MASK;
               p_result = core_out ^ m_chain; p_chain = data; m_busy = 1;
            end
            default: m_err = 1;
         endcase
      end
      chk("err_after_frame", 64'(bus.err), 64'(m_err));
   endtask

   task automatic read_frame(input logic [7:0] lit_stat, input logic [63:0] lit_data);
      send_frame(8'h00, 64'h0, 72, 1'b1, lit_stat, lit_data);
   endtask

   // Wait for the in-flight operation to complete, bounded.
   task automatic wait_done();
      int prev;
      bit seen;
      if (!m_busy) return;
      chk("busy_in_run", 64'(bus.busy), 64'd1);
      prev = n_done;
      seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (n_done != prev) seen = 1;
      end
      if (!seen) chk("core_done_timeout", 64'd0, 64'd1);
      @(negedge clk);
      @(negedge clk);
      chk("core_start_pulses", 64'(n_start - s_start), 64'd1);
      chk("core_text_in", last_tin, exp_tin);
      chk("core_encrypt", 64'(bus.core_encrypt), 64'(exp_enc));
      chk("busy_after_done", 64'(bus.busy), 64'd0);
      m_busy = 0; m_rv = 1; m_result = p_result; m_chain = p_chain;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
      chk({tag, "_err"}, 64'(bus.err), 64'd0);
      chk({tag, "_miso"}, 64'(bus.miso), 64'd0);
      chk({tag, "_core_start"}, 64'(bus.core_start), 64'd0);
      chk({tag, "_core_encrypt"}, 64'(bus.core_encrypt), 64'd0);
      chk({tag, "_core_text_in"}, bus.core_text_in, 64'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int          r, nb, s0;
      logic [7:0]  op;
      logic [63:0] d;
      bus.cs_n = 1'b1;
      bus.mosi = 1'b0;
      rst      = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      // ECB encrypt, then read back.
      send_frame(8'h01, 64'h0123456789ABCDEF, 72, 1'b0, 8'h00, 64'h0);
      wait_done();
      read_frame(8'h40, 64'hFEDC45677654CDEF);
      chk("ecb_err", 64'(bus.err), 64'd0);

      // CBC encrypt with loaded IV.
      send_frame(8'h05, 64'h1111111111111111, 72, 1'b0, 8'h00, 64'h0);
      send_frame(8'h03, 64'h0, 72, 1'b0, 8'h00, 64'h0);
      wait_done();
      chk("cbc_enc_tin", last_tin, 64'h1111111111111111);
      read_frame(8'h40, 64'hEEEE1111EEEE1111);

      // CBC decrypt; chain then used by a CBC encrypt of zero.
      send_frame(8'h05, 64'h1111111111111111, 72, 1'b0, 8'h00, 64'h0);
      send_frame(8'h04, 64'hEEEE1111EEEE1111, 72, 1'b0, 8'h00, 64'h0);
      wait_done();
      read_frame(8'h40, 64'h0);
      send_frame(8'h03, 64'h0, 72, 1'b0, 8'h00, 64'h0);
      wait_done();
      chk("cbc_dec_chain", last_tin, 64'hEEEE1111EEEE1111);
      read_frame(8'h40, 64'h1111111111111111);

      // Short frame: error, no start, status 0x20, cleared by status frame.
      s0 = n_start;
      send_frame(8'h01, 64'hA5A5A5A5A5A5A5A5, 20, 1'b0, 8'h00, 64'h0);
      repeat (25) @(negedge clk);
      chk("short_no_start", 64'(n_start), 64'(s0));
      read_frame(8'h20, 64'h1111111111111111);
      chk("err_cleared", 64'(bus.err), 64'd0);

      // Unknown opcode.
      s0 = n_start;
      send_frame(8'h7E, 64'h0, 72, 1'b0, 8'h00, 64'h0);
      repeat (25) @(negedge clk);
      chk("unknown_no_start", 64'(n_start), 64'(s0));
      read_frame(8'h20, 64'h1111111111111111);

      // New frame during RUN: err, result still intact.
      send_frame(8'h01, 64'h0F0F0F0F0F0F0F0F, 72, 1'b0, 8'h00, 64'h0);
      send_frame(8'h00, 64'h0, 8, 1'b1, 8'h80, 64'h0);
      wait_done();
      chk("run_frame_err", 64'(bus.err), 64'd1);
      read_frame(8'h60, 64'h0F0F0F0F0F0F0F0F ^ MASK);

      // Reset mid-RUN, with err set beforehand; stale done must be ignored.
      send_frame(8'h02, 64'h0, 5, 1'b0, 8'h00, 64'h0);
      send_frame(8'h01, 64'h123456789ABCDEF0, 72, 1'b0, 8'h00, 64'h0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_reset_outputs("rst_run");
      rst = 1'b0;
      model_reset();
      repeat (25) @(negedge clk);
      chk("stale_done_busy", 64'(bus.busy), 64'd0);
      read_frame(8'h00, 64'h0);

      // Randomized frames against the model.
      for (int it = 0; it < 40; it++) begin
         r = $urandom_range(0, 9);
         if (r <= 5) op = 8'(r);
         else if (r == 6) op = 8'($urandom_range(6, 255));
         else op = 8'h00;
         d = {$urandom, $urandom};
         r = $urandom_range(0, 99);
         if (r < 12) nb = $urandom_range(1, 71);
         else if (r < 20) nb = 72 + $urandom_range(1, 8);
         else nb = 72;
         send_frame(op, d, nb, 1'b0, 8'h00, 64'h0);
         wait_done();
         if (it % 3 == 0) send_frame(8'h00, 64'h0, 72, 1'b0, 8'h00, 64'h0);
      end

      repeat (5) @(negedge clk);
      chk("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_cipher_ctrl.md
SPI_CIPHER_CTRL -- requirements
Module: spi_cipher_ctrl

Interface
REQ-001 SHALL have parameter BLOCK_W, default 64: cipher block width in bits, multiple of 8, at least 32.
REQ-002 SHALL have parameter IV_RESET, default all-zero: chaining value after reset.
REQ-003 SHALL have port clk, input, 1: single clock (SPI SCK); all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port cs_n, input, 1: SPI chip select, active-low.
REQ-006 SHALL have port mosi, input, 1: SPI data in, MSB first.
REQ-007 SHALL have port miso, output, 1: SPI data out, registered.
REQ-008 SHALL have ports core_start (output, 1, one-cycle pulse), core_encrypt (output, 1), core_text_in (output, BLOCK_W), core_done (input, 1, one-cycle pulse), core_text_out (input, BLOCK_W): external cipher core handshake.
REQ-009 SHALL have port busy, output, 1: high in states ARM and RUN.
REQ-010 SHALL have port err, output, 1: sticky error flag.

Function
REQ-011 SHALL accept frames of 8 command bits followed by BLOCK_W data bits, shifted in while cs_n is low.
REQ-012 SHALL decode opcodes: 0x01 ECB encrypt, 0x02 ECB decrypt, 0x03 CBC encrypt, 0x04 CBC decrypt, 0x05 load chain (IV), 0x00 status-only.
REQ-013 SHALL implement states IDLE, RX_CMD, RX_DATA, ARM, RUN.
REQ-014 SHALL move IDLE->RX_CMD on the first clk edge with cs_n low, capturing the first bit.
REQ-015 SHALL move RX_CMD->RX_DATA after 8 bits, and count data bits with a counter of width clog2(BLOCK_W+1).
REQ-016 SHALL ignore bits beyond BLOCK_W in the same frame.
REQ-017 SHALL, when cs_n rises with a complete frame and a cipher opcode, enter ARM; ARM SHALL drive core_start high for exactly one cycle and then enter RUN.
REQ-018 SHALL drive core_text_in = data XOR chain for CBC encrypt, and = data for all other cipher opcodes.
REQ-019 SHALL drive core_encrypt high for opcodes 0x01 and 0x03.
REQ-020 SHALL, on the core_done edge in RUN, load the result register, update the chain, and return to IDLE.
REQ-021 Result register contents: core_text_out for ECB and CBC encrypt; core_text_out XOR chain for CBC decrypt.
REQ-022 Chain update: result for CBC encrypt; received ciphertext for CBC decrypt; unchanged for ECB.
REQ-023 SHALL, for opcode 0x05, load chain with the data on cs_n rise without starting the core; opcode 0x00 SHALL do nothing.
REQ-024 SHALL shift out on miso, one cycle late through a register: the status byte {busy, result_valid, err, 5'b0} during the command phase, then the result register MSB first during the data phase.
REQ-025 SHALL clear result_valid once a data phase has been read out, and set it on each core_done.
REQ-026 SHALL, if cs_n rises before a complete frame (opcodes 0x00 and 0x05 included), set err, discard the frame, and not assert core_start.
REQ-027 SHALL set err and start nothing for an unknown opcode.
REQ-028 SHALL, if cs_n falls during ARM/RUN, set err and ignore that frame's bits, while still shifting out status and result.
REQ-029 SHALL ignore core_done outside RUN.
REQ-030 SHALL clear err only on a frame carrying opcode 0x00.

Reset
REQ-031 On rst: state IDLE; busy, err, core_start, core_encrypt, miso, result_valid all 0; core_text_in and result register 0; chain = IV_RESET; counters 0.
REQ-032 rst asserted during RUN SHALL abandon the operation, and a later core_done SHALL be ignored.

Structure
REQ-033 SHALL take opcode constants, state encoding, and status bit positions from shared package spi_cipher_pkg.
REQ-034 SHALL instantiate the existing shift_register sub-module (WIDTH = BLOCK_W) for the data/result path; command shift, counter, and FSM stay local.

Verification (core stub: out = in XOR 0xFFFF0000FFFF0000, done 16 cycles after start)
REQ-035 ECB encrypt P=0x0123456789ABCDEF -> one core_start pulse; next frame reads 0xFEDC45677654CDEF; err=0.
REQ-036 Load IV 0x1111111111111111, then CBC encrypt P=0 -> core_text_in=0x1111111111111111; result 0xEEEE1111EEEE1111.
REQ-037 Load IV 0x1111111111111111, then CBC decrypt C=0xEEEE1111EEEE1111 -> result 0x0; chain becomes 0xEEEE1111EEEE1111.
REQ-038 cs_n raised after 20 bits -> err=1, no core_start; status byte reads 0x20; opcode 0x00 frame clears err.
REQ-039 New frame during RUN -> err=1; the in-flight result is still delivered intact.
REQ-040 rst pulse mid-RUN -> all outputs at reset values; a stale core_done is ignored; result_valid=0.
